gate_vector_checker: RTL and testbench
======================================

# gate_vector_checker

Hardware self-checking driver/monitor for a 2-input combinational gate. It drives the exhaustive input sequence AB = 00, 01, 10, 11 on a DUT, samples the DUT output after a programmable hold time, and compares each sample against a 4-entry expected truth table. It reports the result as a per-vector mismatch mask, a mismatch count and a pass flag. It sits beside a gate block in on-chip or FPGA test wrappers, so gate checks run without a simulator testbench.

## Interface
- HOLD_CYCLES, 10, clock cycles each input vector is held before the output is sampled; legal range ≥1.
- ERR_W, 3, width of err_cnt; must be ≥3 (maximum count is 4).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- truth_tbl  in  4  expected DUT output; bit index = {A,B}. AND = 4'b1000, OR = 4'b1110. Captured on the accepted start edge.
- a_out  out  1  DUT input A (MSB of vector index).
- b_out  out  1  DUT input B (LSB of vector index).
- x_in  in  1  DUT output; combinational function of a_out/b_out, same clock domain.
- busy  out  1  high while vectors are applied.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when the last completed run had zero mismatches; held until the next start.
- err_cnt  out  ERR_W  number of mismatching vectors in the last or current run.
- fail_vec  out  4  bit i set if vector i mismatched.

## Operation
- States:
  - IDLE: a_out=b_out=0, busy=0.
  - APPLY: busy=1, a_out/b_out = idx[1:0].
  - DONE: done=1 for exactly one cycle.
- Registers: idx (2 bits), hold counter hcnt (0..HOLD_CYCLES-1), captured table tbl_q.
- IDLE→APPLY on start=1 at a clock edge.
  - Same edge: idx←0, hcnt←0, tbl_q←truth_tbl, err_cnt←0, fail_vec←0, pass←0.
- In APPLY, when hcnt < HOLD_CYCLES-1: hcnt increments.
- In APPLY, when hcnt = HOLD_CYCLES-1, the edge is a sample edge:
  - If x_in ≠ tbl_q[idx]: set fail_vec[idx] and increment err_cnt.
  - hcnt←0.
  - If idx<3: idx increments and stays in APPLY.
  - If idx=3: go to DONE; pass←1 iff no mismatch occurred, including the current sample.
- DONE→IDLE unconditionally on the next edge.
- start is ignored in APPLY and DONE; no queuing. truth_tbl changes during a run have no effect.
- err_cnt and fail_vec update live during a run. They are final and stable from the DONE cycle until the next accepted start.
- Reset, including mid-run, forces these values immediately:
  - state=IDLE, idx=0, hcnt=0, tbl_q=0.
  - a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.

## Timing
- Let E0 be the edge that accepts start; H = HOLD_CYCLES.
- Vector i is driven from edge E0+i·H until edge E0+(i+1)·H.
- x_in for vector i is the value present just before edge E0+(i+1)·H. The DUT settles combinationally within the last hold cycle.
- busy=1 from E0 to E0+4H. done=1 from E0+4H to E0+4H+1. Back in IDLE at E0+4H+1.
- Start-to-done latency is 4H cycles; the earliest next accepted start is at E0+4H+1.
- H=1: each vector lasts one cycle and is compared in that cycle; no idle gap between vectors.
- All outputs are registered. No combinational path from start or x_in to any output.

## Test plan
- H=10, truth_tbl=4'b1000, DUT=AND, start pulse at E0 → a/b sequence 00,01,10,11, each held 10 cycles; done pulse at E0+40; pass=1, err_cnt=0, fail_vec=4'b0000.
- H=10, truth_tbl=4'b1000, DUT output stuck at 0 → done at E0+40, pass=0, err_cnt=1, fail_vec=4'b1000.
- H=4, truth_tbl=4'b1110 (OR), DUT=AND → pass=0, err_cnt=2, fail_vec=4'b0110, done at E0+16.
- H=1, DUT=AND, truth_tbl=4'b1000 → busy for exactly 4 cycles, done at E0+4, pass=1. Then change truth_tbl during a second run → result uses the table captured at start.
- start held high for the whole run and re-pulsed during busy → no restart. Next run begins only at the first start seen in IDLE (E0+41 when start is held, H=10).
- rst_n low at E0+15 of an AND/4'b0110 run → all outputs 0 asynchronously. After release, start → clean run with err_cnt counted from 0.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Exhaustive 2-input gate checker: drives AB = 00..11, samples the gate output
// after a hold time and compares it against a captured 4-entry truth table.
module gate_vector_checker #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       truth_tbl,
    output logic             a_out,
    output logic             b_out,
    input  logic             x_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

    localparam int unsigned HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [3:0]          tbl_q, tbl_d;
    logic                a_d, b_d, busy_d, done_d, pass_d;
    logic [ERR_W-1:0]    err_d;
    logic [3:0]          fail_d;
    logic                mismatch;

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            hcnt_q   <= '0;
            tbl_q    <= 4'd0;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hcnt_q   <= hcnt_d;
            tbl_q    <= tbl_d;
            a_out    <= a_d;
            b_out    <= b_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
            err_cnt  <= err_d;
            fail_vec <= fail_d;
        end
    end

    // Next-state and next-output logic; output registers lead the state by one edge
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hcnt_d   = hcnt_q;
        tbl_d    = tbl_q;
        a_d      = a_out;
        b_d      = b_out;
        busy_d   = busy;
        done_d   = 1'b0;
        pass_d   = pass;
        err_d    = err_cnt;
        fail_d   = fail_vec;
        mismatch = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    idx_d   = 2'd0;
                    hcnt_d  = '0;
                    tbl_d   = truth_tbl;
                    err_d   = '0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end
            end

            S_APPLY: begin
                if (hcnt_q != HCNT_MAX) begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end else begin
                    hcnt_d   = '0;
                    mismatch = (x_in != tbl_q[idx_q]);
                    if (mismatch) begin
                        fail_d[idx_q] = 1'b1;
                        err_d         = err_cnt + ERR_W'(1);
                    end
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        pass_d  = (fail_d == 4'd0);
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        {a_d, b_d} = idx_q + 2'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized scoreboard bench for gate_vector_checker with hold times 4 and 1
// run side by side on the same gate model and truth tables.
module tb_gate_vector_checker;

    typedef struct {
        logic [3:0]  fv;
        int unsigned err;
        logic        pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] truth_tbl;
    logic [3:0] dut_tbl;
    logic       start_s [2];
    logic       a_s     [2];
    logic       b_s     [2];
    logic       x_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic [2:0] err_s   [2];
    logic [3:0] fv_s    [2];

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned H = (g == 0) ? 4 : 1;

        gate_vector_checker #(.HOLD_CYCLES(H), .ERR_W(3)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_s[g]),
            .truth_tbl (truth_tbl),
            .a_out     (a_s[g]),
            .b_out     (b_s[g]),
            .x_in      (x_s[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g]),
            .pass      (pass_s[g]),
            .err_cnt   (err_s[g]),
            .fail_vec  (fv_s[g])
        );

        // Gate under test: arbitrary 2-input function given as a table
        assign x_s[g] = dut_tbl[{a_s[g], b_s[g]}];

        int          rd     = 0;
        int unsigned cyc    = 0;
        bit          in_run = 1'b0;

        // Monitor: vector sequence during busy, result and latency on done
        always @(negedge clk) begin
            if (!rst_n) begin
                in_run = 1'b0;
            end else if (done_s[g]) begin
                cyc++;
                chk($sformatf("latency h%0d", H), cyc, 4 * H);
                chk($sformatf("ab idle on done h%0d", H), {a_s[g], b_s[g]}, 0);
                if (rd < exp_q.size()) begin
                    chk($sformatf("fail_vec h%0d run%0d", H, rd), fv_s[g], exp_q[rd].fv);
                    chk($sformatf("err_cnt h%0d run%0d", H, rd), err_s[g], exp_q[rd].err);
                    chk($sformatf("pass h%0d run%0d", H, rd), pass_s[g], exp_q[rd].pass);
                end else begin
                    chk($sformatf("unexpected done h%0d", H), 1, 0);
                end
                rd++;
                in_run = 1'b0;
            end else if (busy_s[g]) begin
                if (!in_run) begin
                    in_run = 1'b1;
                    cyc    = 0;
                end else begin
                    cyc++;
                end
                chk($sformatf("ab vector h%0d", H), {a_s[g], b_s[g]}, (cyc / H) % 4);
            end else begin
                in_run = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s a/b i%0d", tag, g), {a_s[g], b_s[g]}, 0);
            chk($sformatf("%s busy/done i%0d", tag, g), {busy_s[g], done_s[g]}, 0);
            chk($sformatf("%s pass i%0d", tag, g), pass_s[g], 0);
            chk($sformatf("%s err/fv i%0d", tag, g), {err_s[g], fv_s[g]}, 0);
        end
    endtask

    // One run on both instances; abort_at>0 asserts reset just after edge E0+abort_at
    task automatic do_run(input logic [3:0] t, input logic [3:0] d, input int abort_at);
        exp_t e;
        @(negedge clk);
        dut_tbl    = d;
        truth_tbl  = t;
        start_s[0] = 1'b1;
        start_s[1] = 1'b1;
        if (abort_at == 0) begin
            e.fv   = t ^ d;
            e.err  = $countones(t ^ d);
            e.pass = (t == d);
            exp_q.push_back(e);
        end
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            start_s[0] = (c <= 16) ? 1'($urandom_range(1)) : 1'b0;
            start_s[1] = (c <= 4)  ? 1'($urandom_range(1)) : 1'b0;
            truth_tbl  = 4'($urandom);
            if (c == abort_at) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 check_all_zero("async reset");
                start_s[0] = 1'b0;
                start_s[1] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [3:0] t;
        logic [3:0] d;
        rst_n      = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        truth_tbl  = 4'd0;
        dut_tbl    = 4'd0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle after reset");

        do_run(4'b1000, 4'b1000, 0);
        do_run(4'b1000, 4'b0000, 0);
        do_run(4'b1110, 4'b1000, 0);
        do_run(4'b0110, 4'b1000, 3);
        do_run(4'b1000, 4'b1000, 0);

        for (int r = 0; r < 24; r++) begin
            t = 4'($urandom);
            d = ($urandom_range(1) == 1) ? t : 4'($urandom);
            do_run(t, d, 0);
        end

        repeat (4) @(negedge clk);
        chk("done count h4", g_inst[0].rd, exp_q.size());
        chk("done count h1", g_inst[1].rd, exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
